// File: rtl/matrix_result_drain.sv
// Captures an NxN result matrix in one cycle and streams it row-major, requantized to OUT_W bits.
// Build option MATRIX_DRAIN_SAT_EN selects saturating requantize; without it the low OUT_W bits wrap.
module matrix_result_drain #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_res_valid,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  i_res_in,
  output logic                             o_res_ready,
  output logic [OUT_W-1:0]                 o_m_data,
  output logic                             o_m_valid,
  input  logic                             i_m_ready,
  output logic [$clog2(N)-1:0]             o_m_row,
  output logic [$clog2(N)-1:0]             o_m_col,
  output logic                             o_m_last,
  output logic                             o_sat_flag,
  output logic [$clog2(N*N):0]             o_sat_cnt
);
  // state    | meaning
  // S_IDLE   | buffer free, res_ready high, waiting for producer done
  // S_STREAM | presenting buffer element r_idx until the consumer takes it

  localparam int IW   = $clog2(N*N);
  localparam int RW   = $clog2(N);
  localparam int SCW  = $clog2(N*N) + 1;
  localparam int LAST = N*N - 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [N-1:0][N-1:0][DATA_W-1:0]  r_buf;
  logic [IW-1:0]                    r_idx;
  logic                             w_capture;
  logic                             w_hs;
  logic                             w_is_last;
  logic [RW-1:0]                    w_row;
  logic [RW-1:0]                    w_col;
  logic [DATA_W-1:0]                w_elem;

  assign w_is_last = (r_idx == IW'(LAST));
  assign w_row     = RW'(r_idx / N);
  assign w_col     = RW'(r_idx % N);
  assign w_elem    = r_buf[w_row][w_col];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_res_ready = 1'b0;
    o_m_valid   = 1'b0;
    w_capture   = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_res_ready = 1'b1;
        w_capture   = i_res_valid;
        if (i_res_valid) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        o_m_valid = 1'b1;
        w_hs      = i_m_ready;
        if (i_m_ready && w_is_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (w_capture) begin
      r_buf <= i_res_in;
      r_idx <= '0;
    end else if (w_hs) begin
      r_idx <= w_is_last ? '0 : r_idx + IW'(1);
    end
  end

  assign o_m_row  = w_row;
  assign o_m_col  = w_col;
  assign o_m_last = o_m_valid && w_is_last;

`ifdef MATRIX_DRAIN_SAT_EN
  logic [DATA_W-OUT_W:0] w_upper;
  logic                  w_clamp;
  logic [SCW-1:0]        r_sat_cnt;

  // Value fits in OUT_W bits only when every bit from the OUT_W sign bit upward agrees.
  assign w_upper = w_elem[DATA_W-1:OUT_W-1];
  assign w_clamp = !((&w_upper) || !(|w_upper));

  always_comb begin
    o_m_data = w_elem[OUT_W-1:0];
    if (w_clamp)
      o_m_data = w_elem[DATA_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  assign o_sat_flag = o_m_valid && w_clamp;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_sat_cnt <= '0;
    else if (w_capture)
      r_sat_cnt <= '0;
    else if (w_hs && w_clamp && (r_sat_cnt != SCW'(N*N)))
      r_sat_cnt <= r_sat_cnt + SCW'(1);
  end

  assign o_sat_cnt = r_sat_cnt;
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_elem[DATA_W-1:OUT_W];
  assign o_m_data    = w_elem[OUT_W-1:0];
  assign o_sat_flag  = 1'b0;
  assign o_sat_cnt   = '0;
`endif

endmodule
